// File: rtl/simon_iter_core.sv
// simon_iter_core: iterative Simon 32/64..64/128 core, one round per clock with an expanded round-key file
module simon_iter_core #(
  parameter int N = 16,
  parameter int M = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           key_valid,
  output logic           key_ready,
  input  logic [N*M-1:0] key,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_mode,
  input  logic [2*N-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_data,
  output logic           key_loaded
);
  localparam int SEL = (N == 16 && M == 4) ? 0 : (N == 24 && M == 3) ? 1 : (N == 24 && M == 4) ? 2 :
                       (N == 32 && M == 3) ? 3 : (N == 32 && M == 4) ? 4 : -1;
  localparam int T  = SEL == 0 ? 32 : SEL <= 2 ? 36 : SEL == 3 ? 42 : 44;
  localparam int ZI = SEL <= 1 ? 0 : SEL - 1;
  localparam int AW = $clog2(T);
  localparam logic [AW-1:0] TL = AW'(T - 1);
  localparam logic [AW-1:0] ML = AW'(M);
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] ZS = ZI == 0 ? Z0 : ZI == 1 ? Z1 : ZI == 2 ? Z2 : Z3;
  if (SEL < 0) begin : g_bad_cfg
    $error("simon_iter_core: unsupported (N,M) pair");
  end
  typedef enum logic [2:0] {NOKEY, KEYEXP, IDLE, RUN, OUT} state_t;
  state_t state, state_n;
  logic [AW-1:0] cnt, cnt_n;
  logic [N-1:0] rk [T];
  logic [N-1:0] x, y, x_n, y_n, t0, knew, rkey;
  logic [5:0] z_idx;
  logic mode, key_acc, blk_acc, last;
  function automatic logic [N-1:0] rol(input logic [N-1:0] a, input int s);
    return (a << s) | (a >> (N - s));
  endfunction
  function automatic logic [N-1:0] f(input logic [N-1:0] a);
    return (rol(a, 1) & rol(a, 8)) ^ rol(a, 2);
  endfunction
  assign key_ready  = state == NOKEY || state == IDLE;
  assign in_ready   = state == IDLE && !key_valid;
  assign out_valid  = state == OUT;
  assign key_loaded = state == IDLE || state == RUN || state == OUT;
  assign key_acc    = key_valid && key_ready;
  assign blk_acc    = in_valid && in_ready;
  assign last       = cnt == TL;
  assign z_idx      = 6'(cnt - ML);
  assign t0   = rol(rk[cnt - AW'(1)], N - 3) ^ (M == 4 ? rk[cnt - AW'(3)] : '0);
  assign knew = ~rk[cnt - ML] ^ t0 ^ rol(t0, N - 1) ^ {{(N-1){1'b0}}, ZS[6'd61 - z_idx]} ^ N'(3);
  assign rkey = rk[mode ? TL - cnt : cnt];
  assign x_n  = mode ? y : y ^ f(x) ^ rkey;
  assign y_n  = mode ? x ^ f(y) ^ rkey : x;
  // round-key file: user words on key accept, then one derived word per KEYEXP cycle
  always_ff @(posedge clk) begin
    if (key_acc)
      for (int i = 0; i < M; i++) rk[i] <= key[i*N +: N];
    else if (state == KEYEXP)
      rk[cnt] <= knew;
  end
  // state and shared key-expansion / round counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= NOKEY;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end
  // next-state logic; a key offered in IDLE wins over a block
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      NOKEY: begin
        state_n = key_acc ? KEYEXP : NOKEY;
        cnt_n   = key_acc ? ML : cnt;
      end
      IDLE: begin
        state_n = key_acc ? KEYEXP : blk_acc ? RUN : IDLE;
        cnt_n   = key_acc ? ML : blk_acc ? '0 : cnt;
      end
      KEYEXP: begin
        state_n = last ? IDLE : KEYEXP;
        cnt_n   = last ? '0 : cnt + AW'(1);
      end
      RUN: begin
        state_n = last ? OUT : RUN;
        cnt_n   = last ? '0 : cnt + AW'(1);
      end
      OUT: state_n = out_ready ? IDLE : OUT;
      default: state_n = NOKEY;
    endcase
  end
  // cipher datapath; result is captured separately so it stays put until the next block finishes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x        <= '0;
      y        <= '0;
      mode     <= 1'b0;
      out_data <= '0;
    end else if (blk_acc) begin
      x    <= in_data[2*N-1:N];
      y    <= in_data[N-1:0];
      mode <= in_mode;
    end else if (state == RUN) begin
      x <= x_n;
      y <= y_n;
      if (last) out_data <= {x_n, y_n};
    end
  end
endmodule

// File: tb/tb_simon_iter_core.sv
// tb_simon_iter_core: checks all five Simon configurations against a word-level reference model
module tb_simon_iter_core;
  logic clk = 0, reset = 1;
  logic key_valid = 0, in_valid = 0, in_mode = 0, out_ready = 0;
  logic [127:0] key = '0;
  logic [63:0] in_data = '0;
  logic [2:0] sel = '0;
  logic [4:0] kr, ir, ov, kl;
  logic [4:0][63:0] od;
  int tests = 0, fails = 0;
  int n, m, t, zi;
  logic [31:0] mk;
  logic [31:0] rkm [44];
  string zs [4] = '{
    "11111010001001010110000111001101111101000100101011000011100110",
    "10001110111110010011000010110101000111011111001001100001011010",
    "10101111011100000011010010011000101000010001111110010110110011",
    "11011011101011000110010111100000010010001010011100110100001111"};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int NN = g == 0 ? 16 : g < 3 ? 24 : 32;
    localparam int MM = (g == 1 || g == 3) ? 3 : 4;
    logic [2*NN-1:0] dout;
    simon_iter_core #(.N(NN), .M(MM)) u_dut (
      .clk(clk), .reset(reset),
      .key_valid(key_valid && sel == g), .key_ready(kr[g]), .key(key[NN*MM-1:0]),
      .in_valid(in_valid && sel == g), .in_ready(ir[g]), .in_mode(in_mode), .in_data(in_data[2*NN-1:0]),
      .out_valid(ov[g]), .out_ready(out_ready && sel == g), .out_data(dout), .key_loaded(kl[g]));
    assign od[g] = 64'(dout);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int s);
    int ns[5] = '{16, 24, 24, 32, 32};
    int ms[5] = '{4, 3, 4, 3, 4};
    int ts[5] = '{32, 36, 36, 42, 44};
    int zz[5] = '{0, 0, 1, 2, 3};
    sel = 3'(s);
    n = ns[s];
    m = ms[s];
    t = ts[s];
    zi = zz[s];
    mk = 32'((64'd1 << n) - 1);
  endtask

  function automatic logic [31:0] rl(input logic [31:0] a, input int s);
    logic [63:0] w;
    w = {32'b0, a & mk};
    return 32'(((w << s) | (w >> (n - s))) & {32'b0, mk});
  endfunction

  function automatic logic [31:0] ff(input logic [31:0] a);
    return (rl(a, 1) & rl(a, 8)) ^ rl(a, 2);
  endfunction

  task automatic expand(input logic [127:0] k);
    logic [31:0] tmp;
    for (int i = 0; i < m; i++) rkm[i] = 32'(k >> (i * n)) & mk;
    for (int i = m; i < t; i++) begin
      tmp = rl(rkm[i-1], n - 3);
      if (m == 4) tmp ^= rkm[i-3];
      tmp ^= rl(tmp, n - 1);
      rkm[i] = (~rkm[i-m] & mk) ^ tmp ^ ((zs[zi].getc((i - m) % 62) == "1") ? 32'd1 : 32'd0) ^ 32'd3;
    end
  endtask

  function automatic logic [63:0] cipher(input logic [63:0] d, input logic md);
    logic [31:0] x, y, tx;
    x = 32'(d >> n) & mk;
    y = 32'(d) & mk;
    for (int r = 0; r < t; r++) begin
      if (!md) begin
        tx = x; x = y ^ ff(x) ^ rkm[r]; y = tx;
      end else begin
        tx = y; y = x ^ ff(y) ^ rkm[t-1-r]; x = tx;
      end
    end
    return ({32'b0, x} << n) | {32'b0, y};
  endfunction

  task automatic load_key(input logic [127:0] k, input string tag);
    int lat;
    key = k;
    key_valid = 1;
    expand(k);
    tests++; if (kr[sel] !== 1'b1) begin fails++; $display("FAIL %s key_ready: got %b want 1", tag, kr[sel]); end
    cyc();
    key_valid = 0;
    in_valid = 0;
    key = {$urandom, $urandom, $urandom, $urandom};
    tests++; if (kr[sel] !== 1'b0 || kl[sel] !== 1'b0 || ir[sel] !== 1'b0) begin
      fails++; $display("FAIL %s keyexp_flags: got kr=%b kl=%b ir=%b want 0 0 0", tag, kr[sel], kl[sel], ir[sel]); end
    lat = 0;
    while (kl[sel] !== 1'b1 && lat < 200) begin cyc(); lat++; end
    tests++; if (lat != t - m) begin fails++; $display("FAIL %s keyexp_len: got %0d want %0d", tag, lat, t - m); end
  endtask

  task automatic run_block(input logic md, input logic [63:0] d, input logic [63:0] want, input string tag, input logic release_out);
    int lat;
    in_data = d;
    in_mode = md;
    in_valid = 1;
    tests++; if (ir[sel] !== 1'b1) begin fails++; $display("FAIL %s in_ready: got %b want 1", tag, ir[sel]); end
    cyc();
    lat = 0;
    while (ov[sel] !== 1'b1 && lat < 300) begin
      in_valid = 1'($urandom_range(0, 1));
      key_valid = 1'($urandom_range(0, 1));
      in_data = {$urandom, $urandom};
      in_mode = 1'($urandom_range(0, 1));
      cyc();
      lat++;
    end
    in_valid = 0;
    key_valid = 0;
    tests++; if (lat != t) begin fails++; $display("FAIL %s latency: got %0d want %0d", tag, lat, t); end
    tests++; if (od[sel] !== want) begin fails++; $display("FAIL %s out_data: got %h want %h", tag, od[sel], want); end
    if (release_out) begin
      out_ready = 1;
      cyc();
      out_ready = 0;
      tests++; if (ov[sel] !== 1'b0 || od[sel] !== want) begin
        fails++; $display("FAIL %s out_handshake: got ov=%b data=%h want ov=0 data=%h", tag, ov[sel], od[sel], want); end
    end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) cyc();
    for (int g = 0; g < 5; g++) begin
      tests++; if ({kr[g], ir[g], ov[g], kl[g]} !== 4'b1000 || od[g] !== 64'd0) begin
        fails++; $display("FAIL reset_%0d: got kr/ir/ov/kl=%b%b%b%b data=%h want 1000 data=0", g, kr[g], ir[g], ov[g], kl[g], od[g]); end
    end
    #3 reset = 0;
    cyc();
  endtask

  task automatic test_vectors16();
    cfg(0);
    load_key(64'h1918_1110_0908_0100, "kv16");
    run_block(0, 64'h6565_6877, 64'hc69b_e9bb, "enc16", 1);
    tests++; if (kl[sel] !== 1'b1) begin fails++; $display("FAIL kl_between: got %b want 1", kl[sel]); end
    run_block(1, 64'hc69b_e9bb, 64'h6565_6877, "dec16", 1);
    tests++; if (kl[sel] !== 1'b1) begin fails++; $display("FAIL kl_after_dec: got %b want 1", kl[sel]); end
  endtask

  task automatic test_stall();
    logic [63:0] d, want;
    cfg(0);
    d = {32'b0, $urandom};
    want = cipher(d, 0);
    run_block(0, d, want, "stall", 0);
    for (int i = 0; i < 10; i++) begin
      key_valid = 1;
      in_valid = 1;
      in_data = {$urandom, $urandom};
      cyc();
      tests++; if ({ov[sel], ir[sel], kr[sel]} !== 3'b100 || od[sel] !== want) begin
        fails++; $display("FAIL stall_%0d: got ov/ir/kr=%b%b%b data=%h want 100 data=%h", i, ov[sel], ir[sel], kr[sel], od[sel], want); end
    end
    key_valid = 0;
    in_valid = 0;
    out_ready = 1;
    cyc();
    out_ready = 0;
    tests++; if ({ov[sel], ir[sel], kr[sel], kl[sel]} !== 4'b0111 || od[sel] !== want) begin
      fails++; $display("FAIL stall_release: got ov/ir/kr/kl=%b%b%b%b data=%h want 0111 data=%h", ov[sel], ir[sel], kr[sel], kl[sel], od[sel], want); end
  endtask

  task automatic test_key_priority();
    logic [63:0] d;
    cfg(0);
    tests++; if (kl[sel] !== 1'b1) begin fails++; $display("FAIL prio_kl_before: got %b want 1", kl[sel]); end
    key_valid = 1;
    in_valid = 1;
    in_data = {$urandom, $urandom};
    #1;
    tests++; if (ir[sel] !== 1'b0 || kr[sel] !== 1'b1) begin
      fails++; $display("FAIL prio_ready: got ir=%b kr=%b want ir=0 kr=1", ir[sel], kr[sel]); end
    load_key({64'b0, $urandom, $urandom}, "prio");
    d = {32'b0, $urandom};
    run_block(1, d, cipher(d, 1), "prio_blk", 1);
  endtask

  task automatic test_reset_mid();
    logic [63:0] d;
    cfg(0);
    d = {32'b0, $urandom};
    in_data = d;
    in_mode = 0;
    in_valid = 1;
    cyc();
    in_valid = 0;
    repeat (10) cyc();
    reset = 1;
    #1;
    tests++; if ({ov[sel], kl[sel], ir[sel], kr[sel]} !== 4'b0001 || od[sel] !== 64'd0) begin
      fails++; $display("FAIL reset_mid: got ov/kl/ir/kr=%b%b%b%b data=%h want 0001 data=0", ov[sel], kl[sel], ir[sel], kr[sel], od[sel]); end
    #2 reset = 0;
    cyc();
    tests++; if (kl[sel] !== 1'b0 || ir[sel] !== 1'b0) begin
      fails++; $display("FAIL reset_mid_nokey: got kl=%b ir=%b want 0 0", kl[sel], ir[sel]); end
    load_key({64'b0, $urandom, $urandom}, "rm_key");
    d = {32'b0, $urandom};
    run_block(0, d, cipher(d, 0), "rm_blk", 1);
  endtask

  task automatic test_simon64();
    cfg(4);
    load_key(128'h1b1a1918_13121110_0b0a0908_03020100, "kv64");
    run_block(0, 64'h656b696c_20646e75, 64'h44c8fc20_b9dfa07a, "enc64", 1);
    run_block(1, 64'h44c8fc20_b9dfa07a, 64'h656b696c_20646e75, "dec64", 1);
  endtask

  task automatic test_random();
    logic [63:0] d;
    logic md;
    for (int s = 0; s < 5; s++) begin
      cfg(s);
      load_key({$urandom, $urandom, $urandom, $urandom}, $sformatf("rkey%0d", s));
      for (int b = 0; b < 4; b++) begin
        d = {$urandom, $urandom} & ((64'd1 << (2 * n)) - 64'd1);
        md = 1'(b & 1);
        run_block(md, d, cipher(d, md), $sformatf("rnd%0d_%0d", s, b), 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors16();
    test_stall();
    test_key_priority();
    test_reset_mid();
    test_simon64();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
